// File: rtl/color_sensor_emulator_if.sv
// Config write port of the color sensor emulator: one channel half-period
// per accepted valid/ready transfer.
interface color_sensor_emulator_if #(
  parameter int CNT_W = 24
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_chan;
  logic [CNT_W-1:0] cfg_half_period;

  modport master (
    output cfg_valid,
    output cfg_chan,
    output cfg_half_period,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_chan,
    input  cfg_half_period,
    output cfg_ready
  );
endinterface

// File: rtl/color_sensor_emulator.sv
// TCS3200-style light-to-frequency sensor emulator. Produces a square wave
// whose half-period is the programmed value of the selected color channel,
// scaled by the S0/S1 frequency scaling, with a settle dead time after any
// filter/scale change.
//
// state  | meaning
// OFF    | output disabled or power-down, freq_out held low
// SETTLE | dead time after enable or filter/scale change, freq_out low
// RUN    | freq_out toggles every eff cycles
module color_sensor_emulator #(
  parameter int CNT_W         = 24,
  parameter int SETTLE_CYCLES = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  color_sensor_emulator_if.slave cfg,
  input  logic                   s0,
  input  logic                   s1,
  input  logic                   s2,
  input  logic                   s3,
  input  logic                   oe_n,
  output logic                   freq_out,
  output logic                   rise_pulse,
  output logic [1:0]             state_dbg
);

  // 6 extra bits hold the worst-case x50 scaling without overflow
  localparam int EW = CNT_W + 6;
  localparam logic [EW-1:0]    ONE_E   = EW'(1);
  localparam logic [EW-1:0]    SET_END = EW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_B   = CNT_W'(1);

  typedef enum logic [1:0] {
    OFF    = 2'b00,
    SETTLE = 2'b01,
    RUN    = 2'b10
  } state_t;

  state_t           state;
  logic [4:0]       sync1, sync2;   // {s0, s1, s2, s3, oe_n}
  logic [3:0]       s_prev;
  logic [CNT_W-1:0] half_red, half_blue, half_clear, half_green;
  logic [CNT_W-1:0] base;
  logic [5:0]       mult;
  logic [EW-1:0]    eff_next, eff_q, cnt;
  logic             go_off, sel_chg, settle_done, run_tc;
  logic             cfg_ready_q;

  assign cfg.cfg_ready = cfg_ready_q;
  assign state_dbg     = state;

  // Effective half-period from the active channel and the scaling select
  always_comb begin
    base = half_red;
    unique case (sync2[2:1])
      2'b00:   base = half_red;
      2'b01:   base = half_blue;
      2'b10:   base = half_clear;
      default: base = half_green;
    endcase
    if (base == '0) base = ONE_B;
    mult = 6'd1;
    unique case (sync2[4:3])
      2'b01:   mult = 6'd50;
      2'b10:   mult = 6'd5;
      default: mult = 6'd1;
    endcase
    eff_next = {6'b0, base} * {{(EW-6){1'b0}}, mult};
  end

  assign go_off      = sync2[0] | (sync2[4:3] == 2'b00);
  assign sel_chg     = (sync2[4:1] != s_prev);
  assign settle_done = (cnt == SET_END);
  assign run_tc      = (cnt == (eff_q - ONE_E));

  // Two-flop synchronizer plus one delayed copy for change detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 5'b00001;
      sync2  <= 5'b00001;
      s_prev <= 4'b0000;
    end else begin
      sync1  <= {s0, s1, s2, s3, oe_n};
      sync2  <= sync1;
      s_prev <= sync2[4:1];
    end
  end

  // Channel half-period registers written over the valid/ready port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_ready_q <= 1'b0;
      half_red    <= CNT_W'(50);
      half_blue   <= CNT_W'(40);
      half_clear  <= CNT_W'(20);
      half_green  <= CNT_W'(60);
    end else begin
      cfg_ready_q <= 1'b1;
      if (cfg.cfg_valid && cfg_ready_q) begin
        unique case (cfg.cfg_chan)
          2'b00:   half_red   <= cfg.cfg_half_period;
          2'b01:   half_blue  <= cfg.cfg_half_period;
          2'b10:   half_clear <= cfg.cfg_half_period;
          default: half_green <= cfg.cfg_half_period;
        endcase
      end
    end
  end

  // Sequencing FSM with registered frequency output and rise strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= OFF;
      cnt        <= '0;
      eff_q      <= '0;
      freq_out   <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      if (go_off) begin
        state    <= OFF;
        cnt      <= '0;
        freq_out <= 1'b0;
      end else begin
        unique case (state)
          OFF: begin
            state    <= SETTLE;
            cnt      <= '0;
            freq_out <= 1'b0;
          end
          SETTLE: begin
            freq_out <= 1'b0;
            if (sel_chg) begin
              cnt <= '0;
            end else if (settle_done) begin
              state <= RUN;
              cnt   <= '0;
              eff_q <= eff_next;
            end else begin
              cnt <= cnt + ONE_E;
            end
          end
          RUN: begin
            if (sel_chg) begin
              state    <= SETTLE;
              cnt      <= '0;
              freq_out <= 1'b0;
            end else if (run_tc) begin
              freq_out   <= ~freq_out;
              rise_pulse <= ~freq_out;
              cnt        <= '0;
              eff_q      <= eff_next;
            end else begin
              cnt <= cnt + ONE_E;
            end
          end
          default: begin
            state    <= OFF;
            cnt      <= '0;
            freq_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/color_sensor_emulator.md
Name: color_sensor_emulator

Overview:
Synthesizable model of a TCS3200-style light-to-frequency color sensor, the driven end of the sensor interface our color measurement logic samples. It takes the photodiode filter select (S2/S3), frequency scaling (S0/S1) and output enable from the rover controller. It produces a square wave whose period is programmed per color channel over a valid/ready config port. It replaces the physical sensor on the board for bring-up and closed-loop regression.

Parameters:
CNT_W, 24, width of each programmed half-period value (clk cycles at 100% scale)
SETTLE_CYCLES, 10, dead time after any filter/scale change, output held low

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
cfg_valid  input  1  config write request
cfg_ready  output  1  config write accepted when high with cfg_valid
cfg_chan  input  2  channel to write: 00 red, 01 blue, 10 clear, 11 green
cfg_half_period  input  CNT_W  half-period in clk cycles at 100% scale
s0  input  1  scaling select, with s1
s1  input  1  scaling select: {s0,s1} 00 power-down, 01 2%, 10 20%, 11 100%
s2  input  1  filter select, with s3
s3  input  1  filter select: {s2,s3} 00 red, 01 blue, 10 clear, 11 green
oe_n  input  1  active-low output enable
freq_out  output  1  emulated sensor frequency output
rise_pulse  output  1  one-cycle pulse in the cycle freq_out goes 0->1
state_dbg  output  2  current FSM state: 00 OFF, 01 SETTLE, 10 RUN

Behaviour:
- Synchronization: s0..s3 and oe_n pass through a 2-flop synchronizer. All references below use the synchronized values. Input-to-detection latency is 2 cycles.
- Reset, while rst_n=0 at a posedge:
  - freq_out=0, rise_pulse=0, state OFF, counters 0, cfg_ready=0.
  - Channel registers load red=50, blue=40, clear=20, green=60.
  - Synchronizer flops load s=0000, oe_n=1.
- cfg_ready=1 whenever not in reset. A write occurs when cfg_valid&cfg_ready at a posedge; the register updates that edge.
- If the written channel is active in RUN, the current half-period completes with the old value and the new value is used from the next toggle.
- Effective half-period: eff = base × mult, with mult = 1 (100%), 5 (20%), 50 (2%).
  - base is the active channel register; base=0 is treated as 1.
  - eff is computed in CNT_W+6 bits with no overflow possible; the counter is CNT_W+6 bits.
  - eff is latched at each toggle and at SETTLE exit.
- FSM:
  - OFF: freq_out=0, counter=0. Exit to SETTLE when oe_n=0 and {s0,s1}!=00.
  - SETTLE: freq_out=0; count SETTLE_CYCLES cycles, then go to RUN with counter=0 and freq_out low.
  - RUN: counter increments each cycle. When counter==eff-1, freq_out toggles and counter<=0. Each level therefore lasts exactly eff cycles, and the first rise occurs eff cycles after RUN entry.
- Any change of synchronized {s0..s3} versus the previous cycle, while oe_n=0 and not power-down:
  - From RUN or SETTLE, go to SETTLE; the settle count restarts and freq_out<=0 in the same edge.
  - A change during SETTLE extends it.
- oe_n=1 or power-down from any state goes to OFF on the next edge and forces freq_out=0.
- rise_pulse=1 exactly in the cycle after the edge on which freq_out became 1. It is never asserted by OFF/SETTLE entry.
- A simultaneous cfg write and filter change is allowed: the write takes effect, and SETTLE exit latches eff from the updated register.
- Reset mid-RUN returns to the reset state on that edge regardless of other inputs.

Test Plan:
- Reset defaults: hold rst_n=0 for 3 cycles, release with s=1111 (100%, green), oe_n=0 -> state OFF for 2 sync cycles, then SETTLE for 10 cycles, then RUN; freq_out low 60 cycles, high 60, period 120; rise_pulse every 120 cycles.
- Program red half=3 at 100%, {s2,s3}=00 -> after settle, freq_out period 6 cycles (3 low/3 high); switch {s0,s1}=10 -> 10 low cycles, then period 30 (15/15).
- Filter change mid-high-level from red to blue (base 40, 100%) -> freq_out drops to 0 on detection edge, stays low 10+40 cycles, then toggles every 40; no rise_pulse during settle.
- cfg write red=7 while red is RUN with half 3 -> current half completes at 3 cycles, subsequent halves 7; write to inactive channel has no effect on freq_out.
- cfg_half_period=0 on active channel at 2% -> eff=50 cycles per half; {s0,s1}=00 or oe_n=1 -> state OFF, freq_out=0 within 3 cycles of input change.
- Reset asserted mid-RUN with freq_out=1 -> next edge freq_out=0, state OFF, channel registers back to 50/40/20/60.
